// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared widths for the two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package mem_arbiter_pkg;
    localparam int ADDR_W = `ADDR_WIDTH;
    localparam int DATA_W = `DATA_WIDTH;
endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Requester-side handshake bundle for both arbiter ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
    logic                               req0;
    logic                               req1;
    logic                               we0;
    logic                               we1;
    logic [mem_arbiter_pkg::ADDR_W-1:0] addr0;
    logic [mem_arbiter_pkg::ADDR_W-1:0] addr1;
    logic [mem_arbiter_pkg::DATA_W-1:0] wdata0;
    logic [mem_arbiter_pkg::DATA_W-1:0] wdata1;
    logic                               ack0;
    logic                               ack1;
    logic [mem_arbiter_pkg::DATA_W-1:0] rdata0;
    logic [mem_arbiter_pkg::DATA_W-1:0] rdata1;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant; on a tie the port not last granted wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  wire logic req0,
    input  wire logic req1,
    input  wire logic last,
    output logic      gnt0,
    output logic      gnt1
);
    // last=1 means port 1 was granted most recently
    assign gnt0 = req0 & (~req1 | last);
    assign gnt1 = req1 & (~req0 | ~last);
endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester round-robin arbiter onto a single tristate memory bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst,
    mem_arbiter_if.slave             bus,
    output logic                     mem_wr,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    inout  wire  [DATA_W-1:0]        mem_data,
    output logic                     busy
);
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RDCAP  = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_ACCESS = c_ST_ACCESS,
        ST_RDCAP  = c_ST_RDCAP,
        ST_RESP   = c_ST_RESP
    } state_t;

    state_t              r_state;
    logic                r_last;
    logic                r_win;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_wr;
    logic                r_mem_rd;
    logic                r_ack0;
    logic                r_ack1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                r_busy;

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;

    rr_arb2 u_rr_arb2 (
        .req0 (bus.req0),
        .req1 (bus.req1),
        .last (r_last),
        .gnt0 (w_gnt0),
        .gnt1 (w_gnt1)
    );

    assign w_we    = w_gnt1 ? bus.we1    : bus.we0;
    assign w_addr  = w_gnt1 ? bus.addr1  : bus.addr0;
    assign w_wdata = w_gnt1 ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_win      <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_mem_addr <= '0;
            r_mem_wr   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_win      <= w_gnt1;
                        r_last     <= w_gnt1;
                        r_we       <= w_we;
                        r_wdata    <= w_wdata;
                        r_mem_addr <= w_addr;
                        r_mem_wr   <= w_we;
                        r_mem_rd   <= ~w_we;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_we) begin
                        r_mem_wr <= 1'b0;
                        r_ack0   <= ~r_win;
                        r_ack1   <= r_win;
                        r_state  <= ST_RESP;
                    end else begin
                        r_state  <= ST_RDCAP;
                    end
                end
                ST_RDCAP: begin
                    // memory has had a full cycle of mem_rd to settle the bus
                    if (r_win) begin
                        r_rdata1 <= mem_data;
                    end else begin
                        r_rdata0 <= mem_data;
                    end
                    r_mem_rd <= 1'b0;
                    r_ack0   <= ~r_win;
                    r_ack1   <= r_win;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_data   = r_mem_wr ? r_wdata : {DATA_W{1'bz}};
    assign mem_wr     = r_mem_wr;
    assign mem_rd     = r_mem_rd;
    assign mem_addr   = r_mem_addr;
    assign busy       = r_busy;
    assign bus.ack0   = r_ack0;
    assign bus.ack1   = r_ack1;
    assign bus.rdata0 = r_rdata0;
    assign bus.rdata1 = r_rdata1;
endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed scoreboard bench for mem_arbiter with a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    logic       clk;
    logic       rst;
    logic       mem_wr;
    logic       mem_rd;
    logic [4:0] mem_addr;
    wire  [7:0] mem_data;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         port;
        logic       we;
        logic [7:0] data;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] mem [0:31];

    mem_arbiter_if bif ();

    mem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif),
        .mem_wr   (mem_wr),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model; parks the bus at 8'hC3 when idle so stray DUT drive shows up
    assign mem_data = mem_wr ? 8'bz : (mem_rd ? mem[mem_addr] : 8'hC3);
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe_exclusive", {31'd0, mem_wr & mem_rd}, 32'd0);
            if (!mem_wr && !mem_rd) chk("bus_idle_z", {24'd0, mem_data}, 32'h0000_00C3);
            if (bif.ack0 || bif.ack1) begin
                chk("ack_exclusive", {31'd0, bif.ack0 & bif.ack1}, 32'd0);
                chk("busy_in_resp", {31'd0, busy}, 32'd1);
                checks++;
                assert (sbq.size() != 0) else begin
                    failures++;
                    $error("FAIL sb_underflow observed=ack expected=no_ack");
                end
                if (sbq.size() != 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("ack_port", bif.ack1 ? 32'd1 : 32'd0, e.port);
                    if (!e.we)
                        chk("rdata", {24'd0, (e.port == 1) ? bif.rdata1 : bif.rdata0}, {24'd0, e.data});
                end
            end
        end
    end

    task automatic access(input int p, input logic we, input logic [4:0] a,
                          input logic [7:0] d, output int lat);
        int t0;
        bit got;
        if (p == 0) begin
            bif.req0 = 1'b1; bif.we0 = we; bif.addr0 = a; bif.wdata0 = d;
        end else begin
            bif.req1 = 1'b1; bif.we1 = we; bif.addr1 = a; bif.wdata1 = d;
        end
        t0  = cyc;
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? bif.ack0 : bif.ack1) begin
                got = 1'b1;
                lat = cyc - t0;
            end
        end
        checks++;
        assert (got) else begin
            failures++;
            $error("FAIL ack_timeout port=%0d observed=no_ack expected=ack", p);
        end
        @(posedge clk);
        #1;
        if (p == 0) bif.req0 = 1'b0;
        else        bif.req1 = 1'b0;
    endtask

    task automatic do_write(input int p, input logic [4:0] a, input logic [7:0] d, output int lat);
        sbq.push_back('{p, 1'b1, 8'h00});
        access(p, 1'b1, a, d, lat);
    endtask

    task automatic do_read(input int p, input logic [4:0] a, input logic [7:0] d, output int lat);
        sbq.push_back('{p, 1'b0, d});
        access(p, 1'b0, a, 8'h00, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, lat0, lat1;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        rst = 1'b1;
        bif.req0 = 0; bif.req1 = 0; bif.we0 = 0; bif.we1 = 0;
        bif.addr0 = 0; bif.addr1 = 0; bif.wdata0 = 0; bif.wdata1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   {31'd0, busy},     32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr},   32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd},   32'd0);
        chk("rst_addr",   {27'd0, mem_addr}, 32'd0);
        chk("rst_ack",    {30'd0, bif.ack1, bif.ack0}, 32'd0);
        chk("rst_rdata",  {16'd0, bif.rdata1, bif.rdata0}, 32'd0);
        rst = 1'b0;

        // Simultaneous writes straight after reset: port 0 wins the first tie
        sbq.push_back('{0, 1'b1, 8'h00});
        sbq.push_back('{1, 1'b1, 8'h00});
        fork
            access(0, 1'b1, 5'h01, 8'h11, lat0);
            access(1, 1'b1, 5'h02, 8'h22, lat1);
        join
        chk("tie_first_latency", lat0, 32'd2);
        do_read(0, 5'h01, 8'h11, lat);
        do_read(1, 5'h02, 8'h22, lat);

        do_write(0, 5'h1e, 8'hab, lat);
        chk("write_latency", lat, 32'd2);
        do_read(0, 5'h1e, 8'hab, lat);
        chk("read_latency", lat, 32'd3);

        for (int i = 0; i < 32; i++) do_write(0, i[4:0], i[7:0], lat);
        for (int i = 0; i < 32; i++) do_read(1, i[4:0], i[7:0], lat);

        // Port 1 served last, so the contended stream should start with port 0
        for (int k = 0; k < 8; k++) begin
            sbq.push_back('{0, 1'b0, k[7:0]});
            sbq.push_back('{1, 1'b0, 8'(16 + k)});
        end
        fork
            for (int k = 0; k < 8; k++) begin
                int l0;
                access(0, 1'b0, k[4:0], 8'h00, l0);
            end
            for (int k = 0; k < 8; k++) begin
                int l1;
                access(1, 1'b0, 5'(16 + k), 8'h00, l1);
            end
        join
        chk("fair_drained", sbq.size(), 32'd0);

        do_write(0, 5'h1e, 8'hab, lat);
        do_write(0, 5'h1e, 8'h19, lat);
        do_write(0, 5'h1e, 8'h34, lat);
        do_read(0, 5'h1e, 8'h34, lat);

        // Reset in the middle of a read
        do_write(0, 5'h03, 8'h5c, lat);
        bif.req1 = 1'b1; bif.we1 = 1'b0; bif.addr1 = 5'h03;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rdcap_strobe", {31'd0, mem_rd}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy",  {31'd0, busy},     32'd0);
        chk("abort_rd",    {31'd0, mem_rd},   32'd0);
        chk("abort_addr",  {27'd0, mem_addr}, 32'd0);
        chk("abort_ack",   {30'd0, bif.ack1, bif.ack0}, 32'd0);
        chk("abort_rdata", {16'd0, bif.rdata1, bif.rdata0}, 32'd0);
        rst = 1'b0;
        bif.req1 = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_ack", {30'd0, bif.ack1, bif.ack0}, 32'd0);
        do_read(1, 5'h03, 8'h5c, lat);
        chk("retry_latency", lat, 32'd3);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_final", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
